// File: rtl/rv32i_types_pkg.sv
// rv32i_types_pkg -- shared types for the out-of-order issue path.
// Holds the completion-buffer tag width and the register scoreboard entry
// type, so the completion buffer and the scoreboard agree on the tag width.
package rv32i_types_pkg;

   localparam int TAG_W         = 4;   // completion-buffer index width
   localparam int NUM_ARCH_REGS = 32;  // architectural integer registers
   localparam int REG_IDX_W     = 5;   // register index width
   localparam int COUNT_W       = 6;   // width of a 0..32 population count

   // One scoreboard entry: pending-producer flag plus the producer's tag.
   typedef struct packed {
      logic             busy;
      logic [TAG_W-1:0] tag;
   } sb_entry_t;

   // A commit only retires the entry if it comes from the newest producer.
   function automatic logic tag_match(input logic [TAG_W-1:0] stored_tag,
                                      input logic [TAG_W-1:0] commit_tag);
      return (stored_tag == commit_tag);
   endfunction

endpackage

// File: rtl/popcount32.sv
// popcount32 -- combinational population count of a 32-bit vector.
// Ports:
//   bits_i  [31:0] vector to count
//   count_o [5:0]  number of set bits (0..32)
module popcount32 (
   input  logic [31:0] bits_i,
   output logic [5:0]  count_o
);

   // Ripple sum of the individual bits.
   always_comb begin
      count_o = 6'd0;
      for (int i = 0; i < 32; i++) begin
         count_o = count_o + {5'd0, bits_i[i]};
      end
   end

endmodule

// File: rtl/ooo_reg_scoreboard.sv
// ooo_reg_scoreboard -- register busy/tag scoreboard for out-of-order issue.
// Each architectural register keeps a busy bit and the completion-buffer tag
// of its newest in-flight producer. Dispatch renames the destination to the
// new tag; a commit clears busy only if its tag is still the newest one.
//
// Optional feature: define OOO_SCOREBOARD_BYPASS_EN to fold a same-cycle
// matching commit into the query outputs (saves one stall cycle). Without
// it, a register reads busy until the edge after its commit.
//
// Ports:
//   CLK, nRST                 clock, async active-low reset
//   dispatch_en/_rd/_tag      destination write of the dispatching instr.
//   wb_en/wb_rd/wb_tag        register-writing commit from completion buffer
//   flush                     squash every in-flight producer
//   rs1, rs2, rd              decode-stage query registers
//   rs1_busy/rs2_busy/rd_busy pending-producer flags (combinational)
//   rs1_tag/rs2_tag           pending producer tags (combinational)
//   busy_count                registered number of busy registers
module ooo_reg_scoreboard #(
   parameter int NUM_REGS = 32,
   parameter int TAG_W    = rv32i_types_pkg::TAG_W
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             dispatch_en,
   input  logic [4:0]       dispatch_rd,
   input  logic [TAG_W-1:0] dispatch_tag,
   input  logic             wb_en,
   input  logic [4:0]       wb_rd,
   input  logic [TAG_W-1:0] wb_tag,
   input  logic             flush,
   input  logic [4:0]       rs1,
   input  logic [4:0]       rs2,
   input  logic [4:0]       rd,
   output logic             rs1_busy,
   output logic             rs2_busy,
   output logic             rd_busy,
   output logic [TAG_W-1:0] rs1_tag,
   output logic [TAG_W-1:0] rs2_tag,
   output logic [5:0]       busy_count
);

   import rv32i_types_pkg::*;

   sb_entry_t   entry_q [NUM_REGS];
   sb_entry_t   entry_d [NUM_REGS];
   logic [31:0] busy_vec_d;
   logic [5:0]  pop_d;
   logic [5:0]  busy_count_q;

   // Next-state per register: flush beats dispatch beats commit; x0 stays clear.
   always_comb begin
      for (int r = 0; r < NUM_REGS; r++) begin
         entry_d[r] = entry_q[r];
         if (r == 0) begin
            entry_d[r] = '0;
         end else if (flush) begin
            // Tags are left in place; only the busy bits are squashed.
            entry_d[r].busy = 1'b0;
         end else if (dispatch_en && (dispatch_rd == REG_IDX_W'(r))) begin
            entry_d[r].busy = 1'b1;
            entry_d[r].tag  = dispatch_tag;
         end else if (wb_en && (wb_rd == REG_IDX_W'(r)) &&
                      tag_match(entry_q[r].tag, wb_tag)) begin
            entry_d[r].busy = 1'b0;
         end else begin
            entry_d[r] = entry_q[r];
         end
      end
   end

   // Gather next-state busy bits so the count is registered alongside them.
   always_comb begin
      busy_vec_d = 32'd0;
      for (int r = 0; r < NUM_REGS; r++) begin
         busy_vec_d[r] = entry_d[r].busy;
      end
   end

   popcount32 u_popcount (
      .bits_i  (busy_vec_d),
      .count_o (pop_d)
   );

   // Scoreboard state and busy count registers.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            entry_q[r] <= '0;
         end
         busy_count_q <= 6'd0;
      end else begin
         for (int r = 0; r < NUM_REGS; r++) begin
            entry_q[r] <= entry_d[r];
         end
         busy_count_q <= pop_d;
      end
   end

   assign busy_count = busy_count_q;

   // Zero-latency queries from registered state, optionally bypassing a commit.
   always_comb begin
      rs1_busy = entry_q[rs1].busy;
      rs2_busy = entry_q[rs2].busy;
      rd_busy  = entry_q[rd].busy;
      rs1_tag  = entry_q[rs1].tag;
      rs2_tag  = entry_q[rs2].tag;
`ifdef OOO_SCOREBOARD_BYPASS_EN
      if (wb_en && (wb_rd == rs1) && tag_match(entry_q[rs1].tag, wb_tag)) begin
         rs1_busy = 1'b0;
      end else begin
         rs1_busy = entry_q[rs1].busy;
      end
      if (wb_en && (wb_rd == rs2) && tag_match(entry_q[rs2].tag, wb_tag)) begin
         rs2_busy = 1'b0;
      end else begin
         rs2_busy = entry_q[rs2].busy;
      end
      if (wb_en && (wb_rd == rd) && tag_match(entry_q[rd].tag, wb_tag)) begin
         rd_busy = 1'b0;
      end else begin
         rd_busy = entry_q[rd].busy;
      end
`endif
   end

endmodule

// File: tb/tb_ooo_reg_scoreboard.sv
// tb_ooo_reg_scoreboard -- directed, table-driven bench for the scoreboard.
module tb_ooo_reg_scoreboard;

   logic       CLK;
   logic       nRST;
   logic       dispatch_en;
   logic [4:0] dispatch_rd;
   logic [3:0] dispatch_tag;
   logic       wb_en;
   logic [4:0] wb_rd;
   logic [3:0] wb_tag;
   logic       flush;
   logic [4:0] rs1, rs2, rd;
   logic       rs1_busy, rs2_busy, rd_busy;
   logic [3:0] rs1_tag, rs2_tag;
   logic [5:0] busy_count;

   int n_checks = 0;
   int n_fail   = 0;

   ooo_reg_scoreboard dut (
      .CLK          (CLK),
      .nRST         (nRST),
      .dispatch_en  (dispatch_en),
      .dispatch_rd  (dispatch_rd),
      .dispatch_tag (dispatch_tag),
      .wb_en        (wb_en),
      .wb_rd        (wb_rd),
      .wb_tag       (wb_tag),
      .flush        (flush),
      .rs1          (rs1),
      .rs2          (rs2),
      .rd           (rd),
      .rs1_busy     (rs1_busy),
      .rs2_busy     (rs2_busy),
      .rd_busy      (rd_busy),
      .rs1_tag      (rs1_tag),
      .rs2_tag      (rs2_tag),
      .busy_count   (busy_count)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      string      name;
      logic       de;
      logic [4:0] drd;
      logic [3:0] dtag;
      logic       we;
      logic [4:0] wrd;
      logic [3:0] wtag;
      logic       fl;
      logic [4:0] q1, q2, qd;
      logic       e1b;
      logic [3:0] e1t;
      logic       e2b;
      logic [3:0] e2t;
      logic       edb;
      logic [5:0] ecnt;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic add(input string nm,
                      input logic de, input logic [4:0] drd, input logic [3:0] dtag,
                      input logic we, input logic [4:0] wrd, input logic [3:0] wtag,
                      input logic fl,
                      input logic [4:0] q1, input logic [4:0] q2, input logic [4:0] qd,
                      input logic e1b, input logic [3:0] e1t,
                      input logic e2b, input logic [3:0] e2t,
                      input logic edb, input logic [5:0] ecnt);
      vec_t v;
      v.name = nm; v.de = de; v.drd = drd; v.dtag = dtag;
      v.we = we; v.wrd = wrd; v.wtag = wtag; v.fl = fl;
      v.q1 = q1; v.q2 = q2; v.qd = qd;
      v.e1b = e1b; v.e1t = e1t; v.e2b = e2b; v.e2t = e2t;
      v.edb = edb; v.ecnt = ecnt;
      vecs.push_back(v);
   endtask

   task automatic idle_ctrl();
      dispatch_en = 1'b0; dispatch_rd = 5'd0; dispatch_tag = 4'd0;
      wb_en = 1'b0; wb_rd = 5'd0; wb_tag = 4'd0;
      flush = 1'b0;
   endtask

   // Drive one table row for one edge, then check the resulting state with
   // all control inputs quiet so no bypass can colour the reading.
   task automatic apply(input vec_t v);
      @(negedge CLK);
      dispatch_en = v.de; dispatch_rd = v.drd; dispatch_tag = v.dtag;
      wb_en = v.we; wb_rd = v.wrd; wb_tag = v.wtag; flush = v.fl;
      rs1 = v.q1; rs2 = v.q2; rd = v.qd;
      @(posedge CLK);
      #1;
      idle_ctrl();
      #1;
      chk({v.name, ".rs1_busy"}, 32'(rs1_busy), 32'(v.e1b));
      chk({v.name, ".rs1_tag"},  32'(rs1_tag),  32'(v.e1t));
      chk({v.name, ".rs2_busy"}, 32'(rs2_busy), 32'(v.e2b));
      chk({v.name, ".rs2_tag"},  32'(rs2_tag),  32'(v.e2t));
      chk({v.name, ".rd_busy"},  32'(rd_busy),  32'(v.edb));
      chk({v.name, ".busy_count"}, 32'(busy_count), 32'(v.ecnt));
   endtask

   logic exp_bypass_busy;
   logic [4:0] fill_regs [9];

   initial begin
`ifdef OOO_SCOREBOARD_BYPASS_EN
      exp_bypass_busy = 1'b0;
`else
      exp_bypass_busy = 1'b1;
`endif
      fill_regs[0] = 5'd1;  fill_regs[1] = 5'd2;  fill_regs[2] = 5'd3;
      fill_regs[3] = 5'd4;  fill_regs[4] = 5'd5;  fill_regs[5] = 5'd6;
      fill_regs[6] = 5'd8;  fill_regs[7] = 5'd10; fill_regs[8] = 5'd11;

      //   name       de drd    dtag   we wrd    wtag  fl  q1     q2     qd     e1b  e1t   e2b  e2t   edb  cnt
      add("disp5",   1, 5'd5,  4'd3,  0, 5'd0,  4'd0, 0, 5'd5,  5'd0,  5'd5,  1, 4'd3, 0, 4'd0, 1, 6'd1);
      add("commit5", 0, 5'd0,  4'd0,  1, 5'd5,  4'd3, 0, 5'd5,  5'd5,  5'd5,  0, 4'd3, 0, 4'd3, 0, 6'd0);
      add("disp7a",  1, 5'd7,  4'd1,  0, 5'd0,  4'd0, 0, 5'd7,  5'd0,  5'd7,  1, 4'd1, 0, 4'd0, 1, 6'd1);
      add("disp7b",  1, 5'd7,  4'd4,  0, 5'd0,  4'd0, 0, 5'd7,  5'd0,  5'd7,  1, 4'd4, 0, 4'd0, 1, 6'd1);
      add("stale7",  0, 5'd0,  4'd0,  1, 5'd7,  4'd1, 0, 5'd7,  5'd0,  5'd7,  1, 4'd4, 0, 4'd0, 1, 6'd1);
      add("commit7", 0, 5'd0,  4'd0,  1, 5'd7,  4'd4, 0, 5'd7,  5'd0,  5'd7,  0, 4'd4, 0, 4'd0, 0, 6'd0);
      add("disp9",   1, 5'd9,  4'd5,  0, 5'd0,  4'd0, 0, 5'd9,  5'd0,  5'd9,  1, 4'd5, 0, 4'd0, 1, 6'd1);
      add("waw9",    1, 5'd9,  4'd2,  1, 5'd9,  4'd5, 0, 5'd9,  5'd0,  5'd9,  1, 4'd2, 0, 4'd0, 1, 6'd1);
      add("disp0",   1, 5'd0,  4'd7,  0, 5'd0,  4'd0, 0, 5'd0,  5'd9,  5'd0,  0, 4'd0, 1, 4'd2, 0, 6'd1);
      add("wb0",     0, 5'd0,  4'd0,  1, 5'd0,  4'd0, 0, 5'd0,  5'd9,  5'd0,  0, 4'd0, 1, 4'd2, 0, 6'd1);
      for (int i = 0; i < 9; i++) begin
         add($sformatf("fill%0d", fill_regs[i]), 1, fill_regs[i], fill_regs[i][3:0],
             0, 5'd0, 4'd0, 0, fill_regs[i], 5'd9, fill_regs[i],
             1, fill_regs[i][3:0], 1, 4'd2, 1, 6'(i + 2));
      end
      add("flush",   1, 5'd3,  4'd9,  1, 5'd9,  4'd2, 1, 5'd3,  5'd9,  5'd1,  0, 4'd3, 0, 4'd2, 0, 6'd0);
      add("disp12",  1, 5'd12, 4'd6,  0, 5'd0,  4'd0, 0, 5'd12, 5'd12, 5'd12, 1, 4'd6, 1, 4'd6, 1, 6'd1);

      // Reset state
      nRST = 1'b0;
      idle_ctrl();
      rs1 = 5'd5; rs2 = 5'd7; rd = 5'd9;
      #12;
      chk("reset.rs1_busy", 32'(rs1_busy), 32'd0);
      chk("reset.rs2_busy", 32'(rs2_busy), 32'd0);
      chk("reset.busy_count", 32'(busy_count), 32'd0);
      @(negedge CLK);
      nRST = 1'b1;

      foreach (vecs[i]) apply(vecs[i]);

      // Non-matching commit never bypasses: reg 12 stays busy in and after the cycle.
      @(negedge CLK);
      wb_en = 1'b1; wb_rd = 5'd12; wb_tag = 4'd5; rs2 = 5'd12;
      #1;
      chk("stale12.same_cycle", 32'(rs2_busy), 32'd1);
      @(posedge CLK);
      #1;
      idle_ctrl();
      #1;
      chk("stale12.after", 32'(rs2_busy), 32'd1);

      // Matching commit: bypass clears the query in the commit cycle.
      @(negedge CLK);
      wb_en = 1'b1; wb_rd = 5'd12; wb_tag = 4'd6; rs2 = 5'd12; rd = 5'd12;
      #1;
      chk("byp12.rs2_same_cycle", 32'(rs2_busy), 32'(exp_bypass_busy));
      chk("byp12.rd_same_cycle",  32'(rd_busy),  32'(exp_bypass_busy));
      chk("byp12.count_same_cycle", 32'(busy_count), 32'd1);
      @(posedge CLK);
      #1;
      idle_ctrl();
      #1;
      chk("byp12.rs2_next", 32'(rs2_busy), 32'd0);
      chk("byp12.count_next", 32'(busy_count), 32'd0);

      // Reset mid-operation discards a pending dispatch.
      @(negedge CLK);
      dispatch_en = 1'b1; dispatch_rd = 5'd20; dispatch_tag = 4'd8;
      @(posedge CLK);
      #1;
      idle_ctrl();
      rs1 = 5'd20; rs2 = 5'd21;
      #1;
      chk("pre_rst.rs1_busy", 32'(rs1_busy), 32'd1);
      chk("pre_rst.rs1_tag", 32'(rs1_tag), 32'd8);
      @(negedge CLK);
      dispatch_en = 1'b1; dispatch_rd = 5'd21; dispatch_tag = 4'd1;
      nRST = 1'b0;
      #1;
      chk("rst_async.rs1_busy", 32'(rs1_busy), 32'd0);
      chk("rst_async.rs1_tag", 32'(rs1_tag), 32'd0);
      chk("rst_async.busy_count", 32'(busy_count), 32'd0);
      @(negedge CLK);
      idle_ctrl();
      nRST = 1'b1;
      @(posedge CLK);
      #1;
      chk("post_rst.rs2_busy", 32'(rs2_busy), 32'd0);
      chk("post_rst.busy_count", 32'(busy_count), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
